// File: rtl/serial_tx_engine.sv
// serial_tx_engine: accepts a word over valid/ready and shifts it out LSB-first as start/data/parity/stop.
module serial_tx_engine #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  logic [2:0]        state;
  logic [CW-1:0]     baud;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic              tick;
  assign tx_ready = state == IDLE;
  assign busy     = !tx_ready;
  assign tick     = baud == BAUD_MAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx_out  <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      baud <= (tx_ready || tick) ? '0 : baud + 1'b1;
      case (state)
        IDLE:
          if (tx_valid) begin
            state  <= START;
            tx_out <= 1'b0;
            shreg  <= tx_data;
            par    <= ^tx_data ^ PARITY_ODD;
          end
        START:
          if (tick) begin
            state   <= DATA;
            tx_out  <= shreg[0];
            bit_cnt <= '0;
          end
        DATA:
          if (tick) begin
            if (bit_cnt == DATA_LAST) begin
              state   <= PARITY_EN ? PARITY : STOP;
              tx_out  <= PARITY_EN ? par : 1'b1;
              bit_cnt <= '0;
            end else begin
              // shift and present the next bit on the same boundary so tx_out tracks the new LSB
              shreg   <= shreg >> 1;
              tx_out  <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        PARITY:
          if (tick) begin
            state   <= STOP;
            tx_out  <= 1'b1;
            bit_cnt <= '0;
          end
        STOP:
          if (tick) begin
            if (bit_cnt == STOP_LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_serial_tx_engine.sv
// tb_serial_tx_engine: five frame configurations driven with random words, checked by a frame-level scoreboard.
module tb_serial_tx_engine;
  localparam int NCFG   = 5;
  localparam int PERIOD = 10;
  localparam int HALF   = 5;

  typedef struct {
    time        t;
    logic [8:0] d;
    bit         b2b;
  } exp_t;

  logic clk;
  int   vectors;
  int   miscompares;
  bit   fin [NCFG];

  initial clk = 1'b0;
  always #HALF clk = ~clk;

  task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cfg%0d %s: got %0h want %0h at %0t", g, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int DW  = g == 4 ? 5 : 8;
    localparam int CPB = g == 4 ? 2 : 4;
    localparam int SB  = g == 3 ? 2 : 1;
    localparam bit PE  = g == 1 || g == 2;
    localparam bit PO  = g == 2;
    localparam int NB  = 1 + DW + int'(PE) + SB;
    localparam logic [8:0] WORD = g == 0 ? 9'hA5 : g == 3 ? 9'hFF : g == 4 ? 9'h1B : 9'h07;

    logic          rst;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_out;
    logic          busy;
    logic          done;
    logic [DW-1:0] tx_data;
    exp_t          q[$];
    bit            prev_keep;
    time           t_done;

    serial_tx_engine #(
      .DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_EN(PE), .PARITY_ODD(PO)
    ) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .done(done)
    );

    // bit i of the frame: start, data LSB-first, optional parity, then stop bits
    function automatic logic fbit(input logic [8:0] d, input int i);
      if (i == 0) return 1'b0;
      if (i <= DW) return d[i-1];
      if (PE && i == DW + 1) return 1'(($countones(d[DW-1:0]) & 1) ^ int'(PO));
      return 1'b1;
    endfunction

    task automatic send(input logic [8:0] d, input bit keep);
      int n;
      n = 0;
      tx_data  = d[DW-1:0];
      tx_valid = 1'b1;
      @(negedge clk);
      while (!tx_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!tx_ready) begin
        check("accept_timeout", g, 32'(tx_ready), 1);
        tx_valid  = 1'b0;
        prev_keep = 1'b0;
      end else begin
        @(posedge clk);
        q.push_back('{t: $time, d: d, b2b: prev_keep});
        #1;
        tx_data   = DW'($urandom);
        tx_valid  = keep;
        prev_keep = keep;
      end
    endtask

    task automatic poke();
      @(posedge clk);
      #1;
      tx_data  = DW'($urandom);
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
    endtask

    task automatic frame(input exp_t e);
      int   nbad;
      logic want;
      nbad = 0;
      check("start_delay", g, 32'($time - e.t), HALF);
      if (e.b2b) check("b2b_gap", g, 32'($time - t_done), PERIOD);
      for (int j = 0; j < CPB * NB; j++) begin
        if (j != 0) @(negedge clk);
        if (rst) begin
          check("abort_state", g, {tx_out, tx_ready, busy, done}, 4'b1100);
          return;
        end
        want = fbit(e.d, j / CPB);
        if ({tx_out, busy, tx_ready, done} !== {want, 3'b100}) begin
          if (nbad == 0)
            $display("FAIL cfg%0d line data=%0h cycle %0d: out/busy/ready/done=%b want %b",
                     g, e.d, j, {tx_out, busy, tx_ready, done}, {want, 3'b100});
          nbad++;
        end
      end
      check("bad_cycles", g, nbad, 0);
      @(negedge clk);
      check("frame_end", g, {tx_out, tx_ready, busy, done}, 4'b1101);
      t_done = $time;
    endtask

    initial begin
      rst       = 1'b1;
      tx_valid  = 1'b0;
      tx_data   = '0;
      prev_keep = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      send(WORD, 1'b0);
      send(9'h55, 1'b1);
      send(9'h3C, 1'b0);
      poke();
      send(9'($urandom), 1'b0);
      repeat (CPB * 4 + 1) @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      send(WORD, 1'b0);
      for (int i = 0; i < 24; i++) begin
        bit keep;
        keep = i < 23 && $urandom_range(0, 2) == 0;
        send(9'($urandom), keep);
        if (!keep && $urandom_range(0, 1) == 1) poke();
        if (!keep) repeat ($urandom_range(0, 4)) @(posedge clk);
      end
      for (int n = 0; n < 400 && (q.size() != 0 || busy); n++) @(negedge clk);
      repeat (4) @(negedge clk);
      check("drain", g, q.size(), 0);
      fin[g] = 1'b1;
    end

    initial begin
      @(negedge clk);
      check("reset_state", g, {tx_out, tx_ready, busy, done}, 4'b1100);
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (done) check("stray_done", g, done, 0);
          if (!tx_out) begin
            if (q.size() == 0) begin
              check("unexpected_frame", g, tx_out, 1);
              for (int n = 0; n < 1000 && !tx_out && !rst; n++) @(negedge clk);
            end else begin
              frame(q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    bit all;
    all = 1'b0;
    for (int c = 0; c < 80000 && !all; c++) begin
      all = 1'b1;
      for (int i = 0; i < NCFG; i++) all &= fin[i];
      if (!all) @(posedge clk);
    end
    if (!all) begin
      vectors++;
      miscompares++;
      $display("FAIL finish_timeout: drivers still running at %0t, want all done", $time);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_tx_engine.md
# serial_tx_engine

- Parametrised serial transmit engine: accepts a parallel word over a valid/ready handshake and shifts it out LSB-first as an asynchronous serial frame (start, data, optional parity, stop).
- Frame format and bit period are configurable.
- Has its own baud-rate counter, bit counter and data shift register.
- Sits between a producer (register file, FIFO) and the `tx` pad.

## Interface

- `DATA_W`, default 8: data bits per frame; legal range 5–9.
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit; must be ≥ 2.
- `STOP_BITS`, default 1: number of stop bits; 1 or 2.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_data`  in  DATA_W  word to send; sampled only on the accept edge.
- `tx_ready`  out  1  engine can accept a word; high only in IDLE.
- `tx_out`  out  1  serial line, registered; idles high.
- `busy`  out  1  high from the cycle after accept until the frame completes.
- `done`  out  1  one-cycle pulse marking frame completion.

## Operation

- **Frame length:** N = 1 + DATA_W + PARITY_EN + STOP_BITS bits. Each bit lasts exactly CLKS_PER_BIT cycles.
- **States:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on accept. Accept means `tx_valid` && `tx_ready` at a rising edge. `tx_data` is captured into the shift register on that edge.
  - START → DATA after one bit period.
  - DATA → PARITY (if `PARITY_EN`) or STOP after DATA_W bit periods.
  - PARITY → STOP after one bit period.
  - STOP → IDLE after STOP_BITS bit periods.
  - Any unused encoding → IDLE.
- **Line values:**
  - START drives `tx_out`=0.
  - DATA drives the shift-register LSB; the register shifts right at each bit boundary.
  - PARITY drives XOR of the captured word, inverted when `PARITY_ODD`=1.
  - STOP and IDLE drive 1.
- **Handshake:**
  - `tx_ready` = (state == IDLE).
  - `tx_valid` while not ready is ignored; no queuing.
  - `tx_data` changes outside the accept edge have no effect on the frame.
- **Counters:**
  - Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit counter width is $clog2(DATA_W+1). It resets to 0 on entry to DATA and STOP.
- **`busy`** = (state != IDLE).
- **`done`** is registered. It is high for exactly the one cycle in which the state has just returned to IDLE from STOP.

## Timing

- **Reset (async):** state=IDLE, `tx_out`=1, `tx_ready`=1, `busy`=0, `done`=0; counters and shift register cleared.
- **Mid-frame reset:** the frame is aborted. `tx_out` returns to 1 immediately, no `done` pulse is produced, and no partial frame resumes after reset release.
- **Frame timing**, with the accept at edge k:
  - From edge k: `tx_out`=0, `busy`=1, `tx_ready`=0.
  - Data bit i is on the line from edge k+CLKS_PER_BIT·(1+i) until the next bit boundary.
  - At edge k+CLKS_PER_BIT·N: state=IDLE, `tx_out`=1, `tx_ready`=1, `busy`=0, `done`=1 for one cycle.
- **Back-to-back:**
  - If `tx_valid` is held high, the next accept happens on edge k+CLKS_PER_BIT·N+1.
  - Sustained frame period is CLKS_PER_BIT·N+1 cycles, i.e. a single IDLE cycle of line-high between frames. That cycle is appended to the final stop bit.
- **`done` vs accept:** `done` and the next accept may fall in the same cycle. `done` is not suppressed.
- **Clean line:** `tx_out` never glitches; it changes only on bit boundaries, reset, or the accept edge.

## Test plan

All scenarios use CLKS_PER_BIT=4 and DATA_W=8 unless noted.

1. **8N1:** accept 0xA5 → `tx_out` shows 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles. `done` pulses exactly 40 cycles after the accept edge.
2. **Even parity** (`PARITY_EN`=1, `PARITY_ODD`=0): send 0x07 → parity bit 1; frame 44 cycles. Repeat with `PARITY_ODD`=1 → parity bit 0.
3. **Two stop bits** (`STOP_BITS`=2): send 0xFF → line held 1 for 8 cycles after the last data bit. `done` at cycle 44.
4. **Back-to-back:** `tx_valid` held high with words 0x55 then 0x3C → second start bit begins 41 cycles after the first. `tx_data` changed mid-frame does not corrupt the first frame.
5. **Ignored request / reset:**
   - Pulse `tx_valid` while `busy` → no effect.
   - Assert `rst` during data bit 3 → `tx_out`=1 and `tx_ready`=1 immediately, with no `done`.
   - A new accept after release produces a full correct frame.
6. **Width sweep:** DATA_W=5, CLKS_PER_BIT=2, send 0x1B → bits 1,1,0,1,1. `done` at cycle 14.
